// File: rtl/int_sequencer_if.sv
// Bundle of the interrupt sequencer request, CP0 and hazard-unit signals.
// The master side (CPU/testbench) drives requests; the slave side (the sequencer) drives strobes.
interface int_sequencer_if #(
  parameter int NSRC   = 3,
  parameter int CODE_W = 2
);
  logic [NSRC-1:0]   in_IRQ;
  logic              in_IE;
  logic [NSRC-1:0]   in_INM;
  logic              in_STALL;
  logic              in_ERET;
  logic              out_FLUSH;
  logic              out_SAVE_EPC;
  logic              out_BK;
  logic              out_NIE;
  logic [CODE_W-1:0] out_CODE;
  logic [NSRC-1:0]   out_PENDING;
  logic              out_BUSY;

  modport master (
    output in_IRQ, in_IE, in_INM, in_STALL, in_ERET,
    input  out_FLUSH, out_SAVE_EPC, out_BK, out_NIE, out_CODE, out_PENDING, out_BUSY
  );

  modport slave (
    input  in_IRQ, in_IE, in_INM, in_STALL, in_ERET,
    output out_FLUSH, out_SAVE_EPC, out_BK, out_NIE, out_CODE, out_PENDING, out_BUSY
  );
endinterface

// File: rtl/int_sequencer.sv
// CP0 interrupt sequencer: IRQ sync/edge-latch, mask, priority select, flush/EPC/IE handshake.
// Define INT_NEST_EN to enable a 2-entry code stack for nested (pre-empting) interrupts.
module int_sequencer #(
  parameter int NSRC        = 3,
  parameter int CODE_W      = 2,
  parameter int SYNC_STAGES = 2
) (
  input logic           in_CLK,
  input logic           in_RST,
  int_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FLUSH   = 3'd1,
    ST_SAVE    = 3'd2,
    ST_SERVICE = 3'd3,
    ST_EXIT    = 3'd4
  } state_t;

  state_t            state_r, state_nx_s;
  logic [NSRC-1:0]   sync_r [SYNC_STAGES];
  logic [NSRC-1:0]   prev_r, rise_s, pending_r, clr_s, eligible_s;
  logic [CODE_W-1:0] sel_s, cur_r, cur_nx_s, code_r;
  logic              take_s;
  logic              flush_r, save_r, bk_r, nie_r, busy_r;
`ifdef INT_NEST_EN
  logic [CODE_W-1:0] stk_r [2];
  logic [1:0]        depth_r;
  logic              push_s, pop_s;
`endif

  assign rise_s     = sync_r[SYNC_STAGES-1] & ~prev_r;
  assign eligible_s = pending_r & ~bus.in_INM & {NSRC{bus.in_IE}};

  // Synchroniser chain and edge-detect history per IRQ line
  always_ff @(posedge in_CLK) begin
    if (in_RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '0;
      prev_r <= '0;
    end else begin
      sync_r[0] <= bus.in_IRQ;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // Priority select: highest eligible index wins, code = index + 1
  always_comb begin
    sel_s = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (eligible_s[i]) sel_s = CODE_W'(i + 1);
    end
  end

  // Pending clear mask for the source being accepted this cycle
  always_comb begin
    clr_s = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (take_s && (sel_s == CODE_W'(i + 1))) clr_s[i] = 1'b1;
    end
  end

  // Next-state and next-code logic
  always_comb begin
    state_nx_s = state_r;
    cur_nx_s   = cur_r;
    take_s     = 1'b0;
`ifdef INT_NEST_EN
    push_s     = 1'b0;
    pop_s      = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if ((|eligible_s) && !bus.in_STALL) begin
          take_s     = 1'b1;
          cur_nx_s   = sel_s;
          state_nx_s = ST_FLUSH;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_FLUSH: state_nx_s = ST_SAVE;
      ST_SAVE:  state_nx_s = ST_SERVICE;
      ST_SERVICE: begin
        if (bus.in_ERET) begin
          state_nx_s = ST_EXIT;
`ifdef INT_NEST_EN
        end else if ((|eligible_s) && (sel_s > cur_r) && (depth_r != 2'd2)) begin
          push_s     = 1'b1;
          take_s     = 1'b1;
          cur_nx_s   = sel_s;
          state_nx_s = ST_FLUSH;
`endif
        end else begin
          state_nx_s = ST_SERVICE;
        end
      end
      ST_EXIT: begin
`ifdef INT_NEST_EN
        if (depth_r != 2'd0) begin
          pop_s      = 1'b1;
          cur_nx_s   = stk_r[depth_r[1]];
          state_nx_s = ST_SERVICE;
        end else begin
          state_nx_s = ST_IDLE;
        end
`else
        state_nx_s = ST_IDLE;
`endif
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State, pending and registered output strobes decoded from the next state
  always_ff @(posedge in_CLK) begin
    if (in_RST) begin
      state_r   <= ST_IDLE;
      cur_r     <= '0;
      pending_r <= '0;
      flush_r   <= 1'b0;
      save_r    <= 1'b0;
      bk_r      <= 1'b0;
      nie_r     <= 1'b0;
      busy_r    <= 1'b0;
      code_r    <= '0;
    end else begin
      state_r   <= state_nx_s;
      cur_r     <= cur_nx_s;
      pending_r <= (pending_r & ~clr_s) | rise_s;
      flush_r   <= (state_nx_s == ST_FLUSH);
      save_r    <= (state_nx_s == ST_SAVE);
      bk_r      <= (state_nx_s == ST_SAVE) || (state_nx_s == ST_EXIT);
      nie_r     <= (state_nx_s == ST_EXIT);
      busy_r    <= (state_nx_s != ST_IDLE);
      code_r    <= ((state_nx_s == ST_FLUSH) || (state_nx_s == ST_SAVE) ||
                    (state_nx_s == ST_SERVICE)) ? cur_nx_s : '0;
    end
  end

`ifdef INT_NEST_EN
  // Nesting stack: push interrupted code on pre-emption, pop on EXIT
  always_ff @(posedge in_CLK) begin
    if (in_RST) begin
      stk_r[0] <= '0;
      stk_r[1] <= '0;
      depth_r  <= 2'd0;
    end else if (push_s) begin
      stk_r[depth_r[0]] <= cur_r;
      depth_r           <= depth_r + 2'd1;
    end else if (pop_s) begin
      depth_r <= depth_r - 2'd1;
    end else begin
      depth_r <= depth_r;
    end
  end
`endif

  assign bus.out_FLUSH    = flush_r;
  assign bus.out_SAVE_EPC = save_r;
  assign bus.out_BK       = bk_r;
  assign bus.out_NIE      = nie_r;
  assign bus.out_CODE     = code_r;
  assign bus.out_PENDING  = pending_r;
  assign bus.out_BUSY     = busy_r;

endmodule
